d_sramlike_bridge: RTL

D_SRAMLIKE_BRIDGE -- requirements
Module: d_sramlike_bridge

---
 rtl/d_sramlike_bridge.sv | 128 ++++++++++++
 1 files changed

// File: rtl/d_sramlike_bridge.sv
// M-stage data access to SRAM-like bus bridge; optional kseg0/kseg1 address map under D_ADDR_MAP_EN.
// Latency: request issued same cycle as mem_en, load data in mem_rdata 2 cycles later at best.
// Backpressure: mem_stall holds the pipeline until DONE; one outstanding transaction maximum.
module d_sramlike_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_flush,
    input  logic        cpu_stall_other,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, stateNext;
    logic        discard, discardNext;
    logic        capture;
    logic        issue;
    logic [31:0] rdataQ;
    logic        wrQ;
    logic [1:0]  sizeQ;
    logic [31:0] addrQ;
    logic [31:0] wdataQ;
    logic [31:0] mappedAddr;

    // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical space
    always_comb begin
`ifdef D_ADDR_MAP_EN
        mappedAddr = (mem_addr[31:30] == 2'b10) ? {3'b000, mem_addr[28:0]} : mem_addr;
`else
        mappedAddr = mem_addr;
`endif
    end

    assign issue = (state == IDLE) && mem_en && !mem_flush;

    always_comb begin
        stateNext   = state;
        discardNext = discard;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    stateNext = data_addr_ok ? WAIT : REQ;
                end
            end
            REQ: begin
                if (mem_flush) begin
                    discardNext = 1'b1;
                end
                if (data_addr_ok) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (mem_flush) begin
                    discardNext = 1'b1;
                end
                // a flush landing on the response cycle still drops the data
                if (data_data_ok) begin
                    if (discard || mem_flush) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext = DONE;
                        capture   = 1'b1;
                    end
                end
            end
            DONE: begin
                if (mem_flush || !cpu_stall_other) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (stateNext == IDLE) begin
            discardNext = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            discard <= 1'b0;
            rdataQ  <= 32'h0;
            wrQ     <= 1'b0;
            sizeQ   <= 2'b00;
            addrQ   <= 32'h0;
            wdataQ  <= 32'h0;
        end else begin
            state   <= stateNext;
            discard <= discardNext;
            if (capture) begin
                rdataQ <= data_rdata;
            end
            if (issue) begin
                wrQ    <= |mem_wen;
                sizeQ  <= mem_size;
                addrQ  <= mappedAddr;
                wdataQ <= mem_wdata;
            end
        end
    end

    // IDLE presents the live M-stage fields; afterwards the latched copy keeps them stable
    assign data_req   = issue || (state == REQ);
    assign data_wr    = (state == IDLE) ? |mem_wen   : wrQ;
    assign data_size  = (state == IDLE) ? mem_size   : sizeQ;
    assign data_addr  = (state == IDLE) ? mappedAddr : addrQ;
    assign data_wdata = (state == IDLE) ? mem_wdata  : wdataQ;

    assign mem_stall = mem_en && !((state == DONE) && !discard);
    assign mem_rdata = rdataQ;

endmodule
